sha256_block_ctrl: RTL and testbench

Sequencer for the SHA-256 compression datapath (`asic2`). It accepts a start command, streams 8 hash words and 16 message words from the 32-bit input bus into the core with a valid/ready handshake, and drives 64 round-enable cycles plus the final hash addition. It then returns the 8 digest words through an output handshake. The controller owns every write strobe, index and round number the core sees; the core holds only data.

---
 rtl/sha256_block_ctrl.sv | 154 +++++++++++++++
 tb/tb_sha256_block_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_ctrl.sv
// Sequencer for the SHA-256 compression core: loads hash/message words over a
// valid/ready bus, runs 64 rounds plus the final add, then streams the digest.
module sha256_block_ctrl #(
  parameter int unsigned ROUNDS     = 64,
  parameter int unsigned HASH_WORDS = 8,
  parameter int unsigned MSG_WORDS  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        init_sel,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] core_data,
  output logic        core_hash_we,
  output logic        core_msg_we,
  output logic [3:0]  word_idx,
  output logic        core_round_en,
  output logic [5:0]  round_idx,
  output logic        w_sched_sel,
  output logic        core_final_add,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HASH,
    LOAD_MSG,
    ROUND,
    FINAL,
    OUT
  } state_t;

  localparam logic [3:0] HASH_LAST   = 4'(HASH_WORDS - 1);
  localparam logic [3:0] MSG_LAST    = 4'(MSG_WORDS - 1);
  localparam logic [5:0] ROUND_LAST  = 6'(ROUNDS - 1);
  localparam logic [5:0] SCHED_START = 6'(MSG_WORDS);
  localparam logic [2:0] OUT_LAST    = 3'(HASH_WORDS - 1);

  state_t     state_q, state_d;
  logic [3:0] word_idx_q, word_idx_d;
  logic [5:0] round_idx_q, round_idx_d;
  logic [2:0] out_idx_q, out_idx_d;
  logic       have_digest_q, have_digest_d;
  logic       done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      word_idx_q    <= '0;
      round_idx_q   <= '0;
      out_idx_q     <= '0;
      have_digest_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_idx_q    <= word_idx_d;
      round_idx_q   <= round_idx_d;
      out_idx_q     <= out_idx_d;
      have_digest_q <= have_digest_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    word_idx_d     = word_idx_q;
    round_idx_d    = round_idx_q;
    out_idx_d      = out_idx_q;
    have_digest_d  = have_digest_q;
    done_d         = 1'b0;
    in_ready       = 1'b0;
    core_hash_we   = 1'b0;
    core_msg_we    = 1'b0;
    core_round_en  = 1'b0;
    w_sched_sel    = 1'b0;
    core_final_add = 1'b0;
    out_valid      = 1'b0;

    case (state_q)
      IDLE: begin
        // Chaining is only honoured once a digest exists in the core.
        if (start) begin
          state_d = (init_sel || !have_digest_q) ? LOAD_HASH : LOAD_MSG;
        end
      end
      LOAD_HASH: begin
        in_ready     = 1'b1;
        core_hash_we = in_valid;
        if (in_valid) begin
          if (word_idx_q == HASH_LAST) begin
            word_idx_d = '0;
            state_d    = LOAD_MSG;
          end else begin
            word_idx_d = word_idx_q + 4'd1;
          end
        end
      end
      LOAD_MSG: begin
        in_ready    = 1'b1;
        core_msg_we = in_valid;
        if (in_valid) begin
          if (word_idx_q == MSG_LAST) begin
            word_idx_d = '0;
            state_d    = ROUND;
          end else begin
            word_idx_d = word_idx_q + 4'd1;
          end
        end
      end
      ROUND: begin
        core_round_en = 1'b1;
        w_sched_sel   = (round_idx_q >= SCHED_START);
        if (round_idx_q == ROUND_LAST) begin
          round_idx_d = '0;
          state_d     = FINAL;
        end else begin
          round_idx_d = round_idx_q + 6'd1;
        end
      end
      FINAL: begin
        core_final_add = 1'b1;
        have_digest_d  = 1'b1;
        state_d        = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_idx_q == OUT_LAST) begin
            out_idx_d = '0;
            state_d   = IDLE;
            done_d    = 1'b1;
          end else begin
            out_idx_d = out_idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign core_data = in_data;
  assign word_idx  = word_idx_q;
  assign round_idx = round_idx_q;
  assign out_idx   = out_idx_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Directed bench for sha256_block_ctrl: table of whole-block scenarios plus
// hand-written reset-state and mid-round reset sequences.
module tb_sha256_block_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        init_sel;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] core_data;
  logic        core_hash_we;
  logic        core_msg_we;
  logic [3:0]  word_idx;
  logic        core_round_en;
  logic [5:0]  round_idx;
  logic        w_sched_sel;
  logic        core_final_add;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_idx;
  logic        busy;
  logic        done;

  sha256_block_ctrl #(.ROUNDS(64), .HASH_WORDS(8), .MSG_WORDS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .init_sel(init_sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_data(core_data), .core_hash_we(core_hash_we), .core_msg_we(core_msg_we),
    .word_idx(word_idx), .core_round_en(core_round_en), .round_idx(round_idx),
    .w_sched_sel(w_sched_sel), .core_final_add(core_final_add),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit init_sel;
    int hstall;          // in_valid gap length at hash word 5
    int mstall;          // in_valid gap length at message word 15
    int ostall;          // out_ready gap length at digest word 3
    bit start_in_round;  // pulse start during round 20
    bit start_on_done;   // issue the next start in the done cycle
    int exp_hash;        // expected core_hash_we pulses
    int exp_done;        // expected cycle of done, counting from the start edge
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] iv  [8];
  logic [31:0] msg [16];
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_block(input vec_t r);
    int n_hash = 0, n_msg = 0, n_round = 0, n_final = 0, n_out = 0;
    int hs = 0, ms = 0, os = 0, done_cyc = -1, cyc;
    start     = 1'b1;
    init_sel  = r.init_sel;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    while (cyc <= 400 && done_cyc < 0) begin
      in_valid = 1'b1;
      if (n_hash == 5 && hs < r.hstall) begin in_valid = 1'b0; hs++; end
      else if (n_msg == 15 && ms < r.mstall) begin in_valid = 1'b0; ms++; end
      if (n_hash < r.exp_hash) in_data = iv[n_hash];
      else if (n_msg < 16)     in_data = msg[n_msg];
      else                     in_data = 32'hdeadbeef;
      out_ready = 1'b1;
      if (n_out == 3 && os < r.ostall) begin out_ready = 1'b0; os++; end
      start = (r.start_in_round && n_round == 20);
      #1;
      if (!in_valid) chk("strobe_in_gap", {30'd0, core_hash_we, core_msg_we}, 0);
      else           chk("in_ready", in_ready, core_hash_we | core_msg_we);
      if (core_hash_we) begin
        chk("hash_idx", word_idx, n_hash);
        chk("hash_data", core_data, iv[n_hash]);
        chk("hash_phase", n_hash < r.exp_hash, 1);
        n_hash++;
      end
      if (core_msg_we) begin
        chk("msg_idx", word_idx, n_msg);
        chk("msg_data", core_data, msg[n_msg]);
        chk("msg_after_hash", n_hash, r.exp_hash);
        n_msg++;
      end
      if (core_round_en) begin
        chk("round_idx", round_idx, n_round);
        chk("w_sched_sel", w_sched_sel, n_round >= 16);
        chk("round_after_load", n_msg, 16);
        chk("round_no_load", {30'd0, core_hash_we, core_msg_we}, 0);
        n_round++;
      end
      if (core_final_add) begin
        chk("final_after_rounds", n_round, 64);
        n_final++;
      end
      if (out_valid) begin
        chk("out_idx", out_idx, n_out);
        if (out_ready) n_out++;
      end
      if (done) begin
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
      end else begin
        chk("busy", busy, 1);
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("done_cycle", done_cyc, r.exp_done);
    chk("hash_count", n_hash, r.exp_hash);
    chk("msg_count", n_msg, 16);
    chk("round_count", n_round, 64);
    chk("final_count", n_final, 1);
    chk("out_count", n_out, 8);
    start = 1'b0;
    if (r.start_on_done) begin
      start = 1'b1;
    end else begin
      @(posedge clk); #1;
      chk("done_pulse_end", done, 0);
      chk("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    vec_t rr;
    iv[0] = 32'h6a09e667; iv[1] = 32'hbb67ae85; iv[2] = 32'h3c6ef372; iv[3] = 32'ha54ff53a;
    iv[4] = 32'h510e527f; iv[5] = 32'h9b05688c; iv[6] = 32'h1f83d9ab; iv[7] = 32'h5be0cd19;
    msg[0] = 32'h02000000;
    for (int i = 1; i < 16; i++) msg[i] = '0;

    //          init hst mst ost sRnd sDone hash done
    vecs[0] = '{1'b0, 0, 0,  0, 1'b0, 1'b0, 8,  98};  // post-reset chain request forces load
    vecs[1] = '{1'b1, 0, 0,  0, 1'b0, 1'b0, 8,  98};  // full block, no stalls
    vecs[2] = '{1'b1, 3, 3,  0, 1'b1, 1'b0, 8, 104};  // input gaps, start ignored in ROUND
    vecs[3] = '{1'b1, 0, 0, 10, 1'b0, 1'b0, 8, 108};  // output backpressure
    vecs[4] = '{1'b0, 0, 0,  0, 1'b0, 1'b0, 0,  90};  // chained block
    vecs[5] = '{1'b0, 0, 0, 10, 1'b0, 1'b1, 0, 100};  // chained + backpressure, start on done
    vecs[6] = '{1'b1, 0, 0,  0, 1'b0, 1'b0, 8,  98};  // back-to-back block

    reset = 1'b0; start = 1'b0; init_sel = 1'b0; in_data = '0;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_strobes", {28'd0, core_hash_we, core_msg_we, core_round_en, core_final_add}, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_idx", {19'd0, word_idx, round_idx, out_idx}, 0);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) run_block(vecs[v]);

    // Abort in the middle of the rounds with in_valid still asserted.
    start = 1'b1; init_sel = 1'b1; in_valid = 1'b1; in_data = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && !(core_round_en && round_idx == 6'd30); i++) begin
      @(posedge clk); #1;
    end
    chk("reach_round30", {26'd0, round_idx}, 30);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_round_idx", round_idx, 0);
    chk("abort_strobes", {28'd0, core_hash_we, core_msg_we, core_round_en, core_final_add}, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out", {28'd0, out_valid, done, w_sched_sel, 1'b0}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rr = '{1'b0, 0, 0, 0, 1'b0, 1'b0, 8, 98};
    run_block(rr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
